// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  localparam int REG_W_DEFAULT   = 5;
  localparam int CNT_W_DEFAULT   = 16;
  localparam int TIMEOUT_DEFAULT = 16;

  // Register specifier 0 is hardwired zero, so a load targeting it never creates a hazard.
  localparam logic [REG_W_DEFAULT-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard inputs and pipeline enable/flush outputs of the stall sequencer.
interface pipeline_stall_ctrl_if #(
  parameter int REG_W = pipe_ctrl_pkg::REG_W_DEFAULT,
  parameter int CNT_W = pipe_ctrl_pkg::CNT_W_DEFAULT
);

  logic             ie_memread;
  logic [REG_W-1:0] ie_rt;
  logic [REG_W-1:0] ii_rs;
  logic [REG_W-1:0] ii_rt;
  logic             mem_req;
  logic             mem_ack;
  logic             br_taken;

  logic             pc_write;
  logic             ii_write;
  logic             ie_write;
  logic             em_write;
  logic             if_flush;
  logic             control_flush;
  logic             mem_err;
  logic [CNT_W-1:0] ld_use_cnt;
  logic [CNT_W-1:0] mem_wait_cnt;

  // Pipeline side: presents hazard information, consumes enables.
  modport master (
    output ie_memread, ie_rt, ii_rs, ii_rt, mem_req, mem_ack, br_taken,
    input  pc_write, ii_write, ie_write, em_write, if_flush, control_flush,
    input  mem_err, ld_use_cnt, mem_wait_cnt
  );

  // Sequencer side.
  modport slave (
    input  ie_memread, ie_rt, ii_rs, ii_rt, mem_req, mem_ack, br_taken,
    output pc_write, ii_write, ie_write, em_write, if_flush, control_flush,
    output mem_err, ld_use_cnt, mem_wait_cnt
  );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: load in ID/EX feeding a source of the IF/ID instruction.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEFAULT
) (
  input  logic             ie_memread,
  input  logic [REG_W-1:0] ie_rt,
  input  logic [REG_W-1:0] ii_rs,
  input  logic [REG_W-1:0] ii_rt,
  output logic             load_use
);

  assign load_use = ie_memread
                  && (ie_rt != REG_W'(REG_ZERO))
                  && ((ie_rt == ii_rs) || (ie_rt == ii_rt));

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer: load-use bubbles, memory-wait freeze with timeout trap, branch flush.
// Optional saturating stall statistics are built when STALL_STATS_EN is defined.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W   = REG_W_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input logic                 clk,
  input logic                 rst_n,
  pipeline_stall_ctrl_if.slave bus
);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_err_q;
  logic             load_use;
  logic             freeze;

  load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
    .ie_memread (bus.ie_memread),
    .ie_rt      (bus.ie_rt),
    .ii_rs      (bus.ii_rs),
    .ii_rt      (bus.ii_rt),
    .load_use   (load_use)
  );

  // A zero-wait access (req and ack together) never freezes.
  assign freeze = (state != ERROR) && bus.mem_req && !bus.mem_ack;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (freeze) begin
            state    <= MEM_WAIT;
            wait_cnt <= CNT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (!freeze) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            state     <= ERROR;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ERROR: ;
        default: state <= ERROR;
      endcase
    end
  end

  logic pc_write, ii_write, ie_write, em_write, if_flush, control_flush;

  // NOTE: every output gets a default first so no path through the block can infer a latch.
  always_comb begin
    pc_write      = 1'b0;
    ii_write      = 1'b0;
    ie_write      = 1'b0;
    em_write      = 1'b0;
    if_flush      = 1'b0;
    control_flush = 1'b0;
    if (rst_n && (state != ERROR) && !freeze) begin
      if (bus.br_taken) begin
        // Taken branch outranks the load-use bubble: the dependent instruction is squashed anyway.
        pc_write      = 1'b1;
        ii_write      = 1'b1;
        ie_write      = 1'b1;
        em_write      = 1'b1;
        if_flush      = 1'b1;
        control_flush = 1'b1;
      end else if (load_use) begin
        ie_write      = 1'b1;
        em_write      = 1'b1;
        control_flush = 1'b1;
      end else begin
        pc_write = 1'b1;
        ii_write = 1'b1;
        ie_write = 1'b1;
        em_write = 1'b1;
      end
    end
  end

  assign bus.pc_write      = pc_write;
  assign bus.ii_write      = ii_write;
  assign bus.ie_write      = ie_write;
  assign bus.em_write      = em_write;
  assign bus.if_flush      = if_flush;
  assign bus.control_flush = control_flush;
  assign bus.mem_err       = mem_err_q;

`ifdef STALL_STATS_EN
  logic [CNT_W-1:0] ld_use_q;
  logic [CNT_W-1:0] mem_wait_q;
  logic             ld_use_stall;

  assign ld_use_stall = (state != ERROR) && !freeze && !bus.br_taken && load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_use_q   <= '0;
      mem_wait_q <= '0;
    end else begin
      if (ld_use_stall && (ld_use_q != '1)) ld_use_q <= ld_use_q + CNT_W'(1);
      if (freeze && (mem_wait_q != '1))     mem_wait_q <= mem_wait_q + CNT_W'(1);
    end
  end

  assign bus.ld_use_cnt   = ld_use_q;
  assign bus.mem_wait_cnt = mem_wait_q;
`else
  assign bus.ld_use_cnt   = '0;
  assign bus.mem_wait_cnt = '0;
`endif

endmodule
